outmap_compress_ctrl: RTL and testbench
=======================================

Name: outmap_compress_ctrl

Overview:
- Sequences one output-map layer through the 16-lane sparse compressor.
- Stages incoming 16-byte output-map rows in a 32-byte sliding window and presents the compressor with up to 16 unconsumed elements per cycle.
- Retires the number of elements the compressor reports as taken.
- Captures each emitted 64-bit compressed word, writes it to memory at an incrementing address, and forces a final flush at end of layer.

Parameters:
ADDR_W, 32, width of memory word address
CNT_W, 16, width of element and word counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; begin layer, sampled only in IDLE
cfg_total_elems  in  CNT_W  elements in layer, latched on start
cfg_base_addr  in  ADDR_W  first write word address, latched on start
in_valid  in  1  input row valid
in_data  in  16x8  input row, element 0 in byte 0
in_ready  out  1  row accepted when in_valid&in_ready
cmp_data  out  16x8  window head, element 0 = oldest unconsumed
cmp_valid_num  out  5  valid elements in cmp_data, 0-16
cmp_start  out  1  one-cycle pulse to compressor at layer begin
cmp_taken_num  in  5  elements consumed by compressor this cycle
cmp_flush  out  1  force compressor to emit partial word
cmp_idle  in  1  compressor holds no pending data
cmp_word  in  64  compressed word
cmp_word_req  in  1  compressed word ready
cmp_mem_ack  out  1  word captured this cycle
mem_wr_req  out  1  write request, held until grant
mem_wr_addr  out  ADDR_W  write address
mem_wr_data  out  64  write data
mem_wr_gnt  in  1  write accepted
busy  out  1  not IDLE
done  out  1  one-cycle end-of-layer pulse
words_written  out  CNT_W  words granted this layer
err_overtake  out  1  sticky; cmp_taken_num > cmp_valid_num seen

Behaviour:
- Reset: all outputs 0, FSM=IDLE, window empty, counters 0, output register empty. Mid-operation reset aborts the layer with no done pulse.
- FSM states:
  - IDLE: on start, latch cfg. If total==0, go to DONE. Else pulse cmp_start, clear words_written and err_overtake, go to RUN.
  - RUN: when elems_taken==total, go to FLUSH.
  - FLUSH: cmp_flush=1. When cmp_idle & !cmp_word_req, go to DRAIN.
  - DRAIN: when output register is empty, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE. start is ignored outside IDLE.
- Window:
  - 32 bytes with occupancy wcnt (0-32).
  - cmp_valid_num = min(wcnt,16). Lanes at or above cmp_valid_num are driven 0.
  - in_ready = (state==RUN) & (wcnt - taken_now <= 16) & (elems_fetched < total). This is a same-cycle take-then-fill computation.
  - On an accepted row, append min(16, total - elems_fetched) bytes after the surviving elements. The upper bytes of a partial last row are discarded.
  - On a take, shift the window down by cmp_taken_num. Take and fill in the same cycle are both applied.
  - If cmp_taken_num > cmp_valid_num: set err_overtake and clamp the take to cmp_valid_num.
- Output path:
  - Single 64-bit output register.
  - cmp_mem_ack = cmp_word_req & (register empty | (mem_wr_req & mem_wr_gnt)), so capture can occur in the same cycle as a grant.
  - On capture: latch mem_wr_data = cmp_word and mem_wr_addr = base + words_captured; assert mem_wr_req next cycle.
  - mem_wr_req stays high with data and address stable until mem_wr_gnt. words_written increments on each grant.
- Arithmetic: all counters use CNT_W bits. The address is base plus the word count, wrapping modulo 2^ADDR_W.

Test Plan:
- total=32, two rows of all nonzero bytes, compressor takes 5/cycle → cmp_valid_num sequence 16,16,16,16,12,7,2. Two in_ready handshakes. done exactly once, after FLUSH and after the final write is granted.
- total=20 → second row accepted with only 4 bytes appended. cmp_valid_num never exceeds 4 after the first 16 are taken. Row bytes 4-15 are never presented.
- cmp_word_req with mem_wr_gnt held low for 5 cycles → cmp_mem_ack low for a second word until the grant. Address goes base, base+1. Data is stable while stalled.
- total=0 on start → busy for 1 cycle, done pulse, no cmp_start, no memory writes.
- cmp_taken_num=9 while cmp_valid_num=4 → err_overtake=1, window advances 4, err_overtake clears on next start.
- Assert rst during RUN with mem_wr_req high → all outputs 0 immediately. A following start runs a clean layer with words_written counting from 0.

Source files
------------

// File: rtl/outmap_compress_ctrl.sv
// Output-map layer sequencer for the 16-lane sparse compressor: stages input rows in a
// 32-byte sliding window and writes each compressed word back through one output register.
module outmap_compress_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       cfg_total_elems,
  input  logic [ADDR_W-1:0]      cfg_base_addr,
  input  logic                   in_valid,
  input  logic [15:0][7:0]       in_data,
  output logic                   in_ready,
  output logic [15:0][7:0]       cmp_data,
  output logic [4:0]             cmp_valid_num,
  output logic                   cmp_start,
  input  logic [4:0]             cmp_taken_num,
  output logic                   cmp_flush,
  input  logic                   cmp_idle,
  input  logic [63:0]            cmp_word,
  input  logic                   cmp_word_req,
  output logic                   cmp_mem_ack,
  output logic                   mem_wr_req,
  output logic [ADDR_W-1:0]      mem_wr_addr,
  output logic [63:0]            mem_wr_data,
  input  logic                   mem_wr_gnt,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       words_written,
  output logic                   err_overtake
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  total;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  elems_taken;
  logic [CNT_W-1:0]  elems_fetched;
  logic [CNT_W-1:0]  words_captured;
  logic [31:0][7:0]  win;
  logic [5:0]        wcnt;

  logic              layer_start;
  logic              run;
  logic              active;
  logic              overtake;
  logic              accept;
  logic              grant;
  logic [4:0]        take;
  logic [4:0]        fill_num;
  logic [5:0]        surv;
  logic [5:0]        wcnt_nxt;
  logic [CNT_W-1:0]  remain;
  logic [31:0][7:0]  win_shift;
  logic [31:0][7:0]  win_nxt;

  assign layer_start = (state == S_IDLE) && start;
  assign run         = (state == S_RUN);
  assign active      = run || (state == S_FLUSH) || (state == S_DRAIN);

  // A take larger than what is presented is flagged and clamped to the presented count.
  assign overtake = run && (cmp_taken_num > cmp_valid_num);
  assign take     = !run ? 5'd0 : (overtake ? cmp_valid_num : cmp_taken_num);
  assign surv     = wcnt - {1'b0, take};
  assign remain   = total - elems_fetched;
  assign fill_num = (remain > CNT_W'(5'd16)) ? 5'd16 : remain[4:0];
  assign in_ready = run && (surv <= 6'd16) && (elems_fetched < total);
  assign accept   = in_valid && in_ready;
  assign wcnt_nxt = surv + (accept ? {1'b0, fill_num} : 6'd0);
  assign win_shift = win >> {take, 3'b000};

  // Next window: survivors shifted to the head, new row bytes appended, zeros above.
  always_comb begin
    win_nxt = '0;
    for (int i = 0; i < 32; i++) begin
      if (6'(i) < surv) begin
        win_nxt[i] = win_shift[i];
      end else if (accept && ((6'(i) - surv) < {1'b0, fill_num})) begin
        win_nxt[i] = in_data[4'(6'(i) - surv)];
      end else begin
        win_nxt[i] = 8'h00;
      end
    end
  end

  // Window bytes above the occupancy are always zero, so the head is presented as-is.
  assign cmp_data = win[15:0];

  // Window contents, occupancy and element counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win           <= '0;
      wcnt          <= 6'd0;
      cmp_valid_num <= 5'd0;
      elems_taken   <= '0;
      elems_fetched <= '0;
    end else if (layer_start) begin
      win           <= '0;
      wcnt          <= 6'd0;
      cmp_valid_num <= 5'd0;
      elems_taken   <= '0;
      elems_fetched <= '0;
    end else begin
      win           <= win_nxt;
      wcnt          <= wcnt_nxt;
      cmp_valid_num <= (wcnt_nxt > 6'd16) ? 5'd16 : wcnt_nxt[4:0];
      elems_taken   <= elems_taken + CNT_W'(take);
      if (accept) begin
        elems_fetched <= elems_fetched + CNT_W'(fill_num);
      end
    end
  end

  // Capture into the output register may coincide with the grant that empties it.
  assign grant       = mem_wr_req && mem_wr_gnt;
  assign cmp_mem_ack = active && cmp_word_req && (!mem_wr_req || mem_wr_gnt);

  // Output register, write counters and sticky overtake flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr_req     <= 1'b0;
      mem_wr_addr    <= '0;
      mem_wr_data    <= 64'h0;
      words_captured <= '0;
      words_written  <= '0;
      err_overtake   <= 1'b0;
    end else if (layer_start) begin
      words_captured <= '0;
      if (cfg_total_elems != '0) begin
        words_written <= '0;
        err_overtake  <= 1'b0;
      end
    end else begin
      if (cmp_mem_ack) begin
        mem_wr_req     <= 1'b1;
        mem_wr_data    <= cmp_word;
        mem_wr_addr    <= base + ADDR_W'(words_captured);
        words_captured <= words_captured + CNT_W'(1'b1);
      end else if (grant) begin
        mem_wr_req <= 1'b0;
      end
      if (grant) begin
        words_written <= words_written + CNT_W'(1'b1);
      end
      if (overtake) begin
        err_overtake <= 1'b1;
      end
    end
  end

  // Layer sequencing FSM with registered status and compressor control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      total     <= '0;
      base      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmp_start <= 1'b0;
      cmp_flush <= 1'b0;
    end else begin
      cmp_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            total <= cfg_total_elems;
            base  <= cfg_base_addr;
            busy  <= 1'b1;
            if (cfg_total_elems == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_RUN;
              cmp_start <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (elems_taken == total) begin
            state     <= S_FLUSH;
            cmp_flush <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (cmp_idle && !cmp_word_req) begin
            state     <= S_DRAIN;
            cmp_flush <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!mem_wr_req) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          cmp_flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_outmap_compress_ctrl.sv
// Directed bench for outmap_compress_ctrl with hand-computed expectations per cycle.
module tb_outmap_compress_ctrl;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [15:0]      cfg_total_elems;
  logic [31:0]      cfg_base_addr;
  logic             in_valid;
  logic [15:0][7:0] in_data;
  logic             in_ready;
  logic [15:0][7:0] cmp_data;
  logic [4:0]       cmp_valid_num;
  logic             cmp_start;
  logic [4:0]       cmp_taken_num;
  logic             cmp_flush;
  logic             cmp_idle;
  logic [63:0]      cmp_word;
  logic             cmp_word_req;
  logic             cmp_mem_ack;
  logic             mem_wr_req;
  logic [31:0]      mem_wr_addr;
  logic [63:0]      mem_wr_data;
  logic             mem_wr_gnt;
  logic             busy;
  logic             done;
  logic [15:0]      words_written;
  logic             err_overtake;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [63:0] W0 = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] W1 = 64'h5A5A_0000_0000_0002;
  localparam logic [63:0] W2 = 64'h1234_5678_9ABC_DEF0;

  // Compare an observed value against its expectation and record the outcome.
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  outmap_compress_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_total_elems(cfg_total_elems), .cfg_base_addr(cfg_base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cmp_data(cmp_data), .cmp_valid_num(cmp_valid_num), .cmp_start(cmp_start),
    .cmp_taken_num(cmp_taken_num), .cmp_flush(cmp_flush), .cmp_idle(cmp_idle),
    .cmp_word(cmp_word), .cmp_word_req(cmp_word_req), .cmp_mem_ack(cmp_mem_ack),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_gnt(mem_wr_gnt), .busy(busy), .done(done),
    .words_written(words_written), .err_overtake(err_overtake)
  );

  // Free-running bench clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0][7:0] row_seq(input logic [7:0] first);
    logic [15:0][7:0] r;
    for (int i = 0; i < 16; i++) r[i] = first + 8'(i);
    return r;
  endfunction

  // Directed stimulus and checks.
  initial begin
    rst = 1'b1; start = 1'b0; cfg_total_elems = 16'd0; cfg_base_addr = 32'd0;
    in_valid = 1'b0; in_data = '0; cmp_taken_num = 5'd0; cmp_idle = 1'b1;
    cmp_word = 64'd0; cmp_word_req = 1'b0; mem_wr_gnt = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", cmp_valid_num, 5'd0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_wr_req", mem_wr_req, 1'b0);
    rst = 1'b0;
    tick();

    // Layer 1: 32 elements, 5 taken per cycle, stalled write-back in FLUSH.
    start = 1'b1; cfg_total_elems = 16'd32; cfg_base_addr = 32'h0000_1000;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = row_seq(8'h01); cmp_taken_num = 5'd0; #1;
    chk("l1_cmp_start", cmp_start, 1'b1);
    chk("l1_busy", busy, 1'b1);
    chk("l1_c0_valid", cmp_valid_num, 5'd0);
    chk("l1_c0_ready", in_ready, 1'b1);
    tick();
    in_data = row_seq(8'h11); cmp_taken_num = 5'd5; #1;
    chk("l1_c1_valid", cmp_valid_num, 5'd16);
    chk("l1_c1_lane0", cmp_data[0], 8'h01);
    chk("l1_c1_lane15", cmp_data[15], 8'h10);
    chk("l1_c1_ready", in_ready, 1'b1);
    chk("l1_c1_start_low", cmp_start, 1'b0);
    tick();
    in_valid = 1'b0; #1;
    chk("l1_c2_valid", cmp_valid_num, 5'd16);
    chk("l1_c2_lane0", cmp_data[0], 8'h06);
    chk("l1_c2_lane15", cmp_data[15], 8'h15);
    chk("l1_c2_ready", in_ready, 1'b0);
    tick(); #1;
    chk("l1_c3_valid", cmp_valid_num, 5'd16);
    chk("l1_c3_lane0", cmp_data[0], 8'h0B);
    tick(); #1;
    chk("l1_c4_valid", cmp_valid_num, 5'd16);
    chk("l1_c4_lane0", cmp_data[0], 8'h10);
    tick(); #1;
    chk("l1_c5_valid", cmp_valid_num, 5'd12);
    chk("l1_c5_lane0", cmp_data[0], 8'h15);
    chk("l1_c5_lane11", cmp_data[11], 8'h20);
    chk("l1_c5_lane12", cmp_data[12], 8'h00);
    tick(); #1;
    chk("l1_c6_valid", cmp_valid_num, 5'd7);
    chk("l1_c6_lane0", cmp_data[0], 8'h1A);
    tick();
    cmp_taken_num = 5'd2; #1;
    chk("l1_c7_valid", cmp_valid_num, 5'd2);
    chk("l1_c7_lane0", cmp_data[0], 8'h1F);
    chk("l1_c7_lane1", cmp_data[1], 8'h20);
    chk("l1_c7_lane2", cmp_data[2], 8'h00);
    tick();
    cmp_taken_num = 5'd0; #1;
    chk("l1_c8_valid", cmp_valid_num, 5'd0);
    chk("l1_c8_flush", cmp_flush, 1'b0);
    tick();
    cmp_idle = 1'b0; cmp_word_req = 1'b1; cmp_word = W0; mem_wr_gnt = 1'b0; #1;
    chk("l1_f0_flush", cmp_flush, 1'b1);
    chk("l1_f0_ack", cmp_mem_ack, 1'b1);
    chk("l1_f0_wr_req", mem_wr_req, 1'b0);
    tick();
    cmp_word = W1; #1;
    chk("l1_f1_wr_req", mem_wr_req, 1'b1);
    chk("l1_f1_addr", mem_wr_addr, 32'h0000_1000);
    chk("l1_f1_data", mem_wr_data, W0);
    chk("l1_f1_ack", cmp_mem_ack, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("l1_stall_ack", cmp_mem_ack, 1'b0);
      chk("l1_stall_data", mem_wr_data, W0);
      chk("l1_stall_addr", mem_wr_addr, 32'h0000_1000);
      chk("l1_stall_words", words_written, 16'd0);
      tick();
    end
    mem_wr_gnt = 1'b1; #1;
    chk("l1_f6_ack", cmp_mem_ack, 1'b1);
    tick();
    mem_wr_gnt = 1'b0; cmp_word_req = 1'b0; cmp_idle = 1'b1; #1;
    chk("l1_f7_wr_req", mem_wr_req, 1'b1);
    chk("l1_f7_addr", mem_wr_addr, 32'h0000_1001);
    chk("l1_f7_data", mem_wr_data, W1);
    chk("l1_f7_words", words_written, 16'd1);
    chk("l1_f7_flush", cmp_flush, 1'b1);
    tick(); #1;
    chk("l1_f8_flush", cmp_flush, 1'b0);
    chk("l1_f8_done", done, 1'b0);
    chk("l1_f8_wr_req", mem_wr_req, 1'b1);
    tick();
    mem_wr_gnt = 1'b1; #1;
    chk("l1_f9_done", done, 1'b0);
    tick();
    mem_wr_gnt = 1'b0; #1;
    chk("l1_f10_wr_req", mem_wr_req, 1'b0);
    chk("l1_f10_words", words_written, 16'd2);
    chk("l1_f10_done", done, 1'b0);
    tick(); #1;
    chk("l1_done", done, 1'b1);
    chk("l1_done_busy", busy, 1'b1);
    tick(); #1;
    chk("l1_after_done", done, 1'b0);
    chk("l1_after_busy", busy, 1'b0);

    // Layer 2: 20 elements, partial last row, overtaking take.
    start = 1'b1; cfg_total_elems = 16'd20; cfg_base_addr = 32'h0000_2000;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = row_seq(8'h01); cmp_taken_num = 5'd0; #1;
    chk("l2_c0_ready", in_ready, 1'b1);
    tick();
    in_data = row_seq(8'hA0); cmp_taken_num = 5'd16; #1;
    chk("l2_c1_valid", cmp_valid_num, 5'd16);
    chk("l2_c1_ready", in_ready, 1'b1);
    tick();
    cmp_taken_num = 5'd9; #1;
    chk("l2_c2_valid", cmp_valid_num, 5'd4);
    chk("l2_c2_lane0", cmp_data[0], 8'hA0);
    chk("l2_c2_lane3", cmp_data[3], 8'hA3);
    chk("l2_c2_lane4", cmp_data[4], 8'h00);
    chk("l2_c2_ready", in_ready, 1'b0);
    chk("l2_c2_err", err_overtake, 1'b0);
    tick();
    in_valid = 1'b0; cmp_taken_num = 5'd0; #1;
    chk("l2_c3_err", err_overtake, 1'b1);
    chk("l2_c3_valid", cmp_valid_num, 5'd0);
    chk("l2_c3_lane0", cmp_data[0], 8'h00);
    tick(); #1;
    chk("l2_c4_flush", cmp_flush, 1'b1);
    tick(); #1;
    chk("l2_c5_flush", cmp_flush, 1'b0);
    tick(); #1;
    chk("l2_done", done, 1'b1);
    chk("l2_words", words_written, 16'd0);
    tick();

    // Layer 3: aborted by reset while a write is pending.
    start = 1'b1; cfg_total_elems = 16'd16; cfg_base_addr = 32'h0000_0100;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = row_seq(8'h40);
    cmp_word_req = 1'b1; cmp_word = W2; #1;
    chk("l3_err_cleared", err_overtake, 1'b0);
    chk("l3_ack", cmp_mem_ack, 1'b1);
    chk("l3_cmp_start", cmp_start, 1'b1);
    tick();
    in_valid = 1'b0; cmp_word_req = 1'b0; #1;
    chk("l3_wr_req", mem_wr_req, 1'b1);
    chk("l3_addr", mem_wr_addr, 32'h0000_0100);
    chk("l3_valid", cmp_valid_num, 5'd16);
    rst = 1'b1; #1;
    chk("l3_rst_wr_req", mem_wr_req, 1'b0);
    chk("l3_rst_addr", mem_wr_addr, 32'h0);
    chk("l3_rst_data", mem_wr_data, 64'h0);
    chk("l3_rst_busy", busy, 1'b0);
    chk("l3_rst_valid", cmp_valid_num, 5'd0);
    chk("l3_rst_data_lanes", cmp_data, 128'h0);
    chk("l3_rst_ready", in_ready, 1'b0);
    chk("l3_rst_flush", cmp_flush, 1'b0);
    chk("l3_rst_done", done, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Layer 4: clean 16-element layer after the abort.
    start = 1'b1; cfg_total_elems = 16'd16; cfg_base_addr = 32'h0000_0200;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = row_seq(8'h40);
    cmp_word_req = 1'b1; cmp_word = W2; #1;
    chk("l4_ack", cmp_mem_ack, 1'b1);
    chk("l4_words0", words_written, 16'd0);
    tick();
    in_valid = 1'b0; cmp_word_req = 1'b0; cmp_taken_num = 5'd16; mem_wr_gnt = 1'b1; #1;
    chk("l4_valid", cmp_valid_num, 5'd16);
    chk("l4_lane0", cmp_data[0], 8'h40);
    chk("l4_addr", mem_wr_addr, 32'h0000_0200);
    chk("l4_data", mem_wr_data, W2);
    tick();
    cmp_taken_num = 5'd0; mem_wr_gnt = 1'b0; #1;
    chk("l4_wr_req_low", mem_wr_req, 1'b0);
    chk("l4_words1", words_written, 16'd1);
    tick(); tick(); tick(); #1;
    chk("l4_done", done, 1'b1);
    chk("l4_done_words", words_written, 16'd1);
    tick();

    // Layer 5: empty layer.
    start = 1'b1; cfg_total_elems = 16'd0; cfg_base_addr = 32'h0000_0300;
    tick();
    start = 1'b0; #1;
    chk("l5_busy", busy, 1'b1);
    chk("l5_done", done, 1'b1);
    chk("l5_no_start", cmp_start, 1'b0);
    chk("l5_no_write", mem_wr_req, 1'b0);
    tick(); #1;
    chk("l5_idle_busy", busy, 1'b0);
    chk("l5_idle_done", done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
